mem_arb: RTL and testbench
==========================

# mem_arb

Round-robin arbiter that shares the processor's single memory port (`mem_ce_o`/`mem_we_o`/`mem_addr_o`/`mem_width_o`/`mem_data_o`/`mem_data_i`, backed by the `mem` adapter and a synchronous-read BRAM) between `NUM_REQ` requesters. Typical requesters are the matcher's table lookups, the executor's writes, and the table-configuration loader. Requesters can lock the port for multi-word accesses, such as a 16-byte match entry read as 4 words. A hold counter bounds how long any requester can keep the lock.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `MAX_HOLD`, 8: maximum consecutive cycles one requester may own the port (≥1).
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset; asynchronous and active-high.
- `req_i` in NUM_REQ: per-requester access request.
- `lock_i` in NUM_REQ: keep ownership after this access.
- `we_i` in NUM_REQ: 1 = write, 0 = read.
- `addr_i` in NUM_REQ×`ADDR_BUS`: packed request addresses, requester k at slice k.
- `width_i` in NUM_REQ×4: access width in bytes (1, 2, 4), packed.
- `wdata_i` in NUM_REQ×`DATA_BUS`: write data, packed.
- `gnt_o` out NUM_REQ: one-hot; access k is issued this cycle.
- `rvalid_o` out NUM_REQ: one-hot; read data for k is on `rdata_o`.
- `rdata_o` out `DATA_BUS`: shared read data, equal to `mem_data_i`.
- `hold_err_o` out 1: sticky; set when a forced release occurs.
- `mem_ce_o`, `mem_we_o`, `mem_addr_o`, `mem_width_o`, `mem_data_o` out: memory port.
- `mem_data_i` in `DATA_BUS`: memory read data, valid one cycle after a read issue.

## Operation
- **Registered state:**
  - `owner_valid`, `owner[$clog2(NUM_REQ)]`
  - `ptr` (round-robin next-highest-priority index)
  - `hold_cnt[$clog2(MAX_HOLD+1)]`
  - `rd_pend` (one-hot copy of the last read grant)
  - `hold_err`
- **FSM:**
  - FREE (`owner_valid=0`):
    - Pick the first `req_i[k]` scanning k = ptr, ptr+1, … modulo NUM_REQ.
    - Grant k. If `lock_i[k]`, go to OWNED(k) with `hold_cnt=1`.
    - `ptr` ← k+1 mod NUM_REQ on every FREE grant.
  - OWNED(k):
    - Only k may be granted; `gnt_o[k]=req_i[k]`. Other requests stall without loss; they must hold their request signals until granted.
    - `hold_cnt` increments every cycle in OWNED, whether or not k issues.
    - Exit to FREE when any of these holds:
      - k issues with `lock_i[k]=0`.
      - k has `req_i[k]=0` and `lock_i[k]=0`.
      - `hold_cnt==MAX_HOLD` at a clock edge. This is a forced release: `hold_err` ← 1 and `ptr` ← k+1.
    - In the forced-release cycle, k's access (if requested) is still granted.
- **Memory port (combinational from the granted requester):**
  - `mem_ce_o = |gnt_o`, `mem_we_o = we_i[g]`.
  - `mem_addr_o`, `mem_width_o`, `mem_data_o` come from slice g.
  - With no grant, all mem outputs are 0.
- **Read return:** `rd_pend` ← `gnt_o & ~we_i`; `rvalid_o = rd_pend`; `rdata_o = mem_data_i` at all times.
- **Width:** `width_i` is passed through unchecked; illegal widths are the `mem` adapter's concern.
- **Reset (async, any state):**
  - `owner_valid=0`, `ptr=0`, `hold_cnt=0`, `rd_pend=0`, `hold_err=0`.
  - The outputs `gnt_o`, `rvalid_o`, `hold_err_o` and `mem_*_o` are therefore 0 until requests arrive.
  - A read granted in the cycle reset asserts never produces `rvalid_o`.

## Timing
- **Grant:** same cycle as the request (0-cycle arbitration) when FREE or owned by the requester.
- **Read:** `rvalid_o[k]` is asserted exactly one cycle after `gnt_o[k]` on a read. Back-to-back reads return on consecutive cycles.
- **Write:** complete at the clock edge of the grant cycle; no response.
- **Lock:** a locked owner issuing every cycle gets MAX_HOLD grants maximum. The next owner is granted in the cycle after release.
- **Simultaneous requests:** lowest index at or after `ptr` wins.
- **Full/idle:** with all requests held high and no locks, grants rotate 0, 1, 2, 0, … one per cycle.

## Test plan
- **Reset:** `rst` held 3 cycles with all `req_i=1` → `gnt_o=0`, `mem_ce_o=0`, `rvalid_o=0`, `hold_err_o=0`. First grant after release is requester 0.
- **Round-robin:** `req_i=3'b111`, no locks, 6 cycles → `gnt_o` sequence 001, 010, 100, 001, 010, 100.
- **Locked burst:** requester 1 reads addresses 0x21c..0x21f with `lock_i[1]=1` on the first 3 and `req_i[0]=1` throughout.
  - `gnt_o=010` for 4 cycles, then `001`.
  - `rvalid_o[1]` on cycles 2..5 with `rdata_o` = b7acf62c, deadbeef, face0001, 00000000 (BRAM preloaded).
- **Forced release:** `MAX_HOLD=8`, requester 2 holds `req`+`lock` indefinitely, requester 0 requesting.
  - 8 grants to 2, then `gnt_o=001`.
  - `hold_err_o` rises at the release edge and stays 1 until reset.
- **Write/read mix:** requester 0 writes 0x12345678 to 0x10; the next cycle requester 1 reads 0x10.
  - Grants on consecutive cycles; `rvalid_o=010` with `rdata_o=0x12345678`; no `rvalid_o` for the write.
- **Reset mid-burst:** `rst` asserted during a locked read burst → outputs 0 immediately, no `rvalid_o` in the following cycle. After release, FREE with `ptr=0`.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port between NUM_REQ
// requesters, with optional multi-cycle locking bounded by MAX_HOLD.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_i/lock_i/we_i        per-requester request, keep-ownership, write flag
//   addr_i/width_i/wdata_i   per-requester access fields, requester k at slice k
//   gnt_o                    one-hot grant; the access is issued this cycle
//   rvalid_o, rdata_o        one-hot read return (one cycle after a read grant)
//   hold_err_o               sticky, set when an owner is forcibly released
//   mem_*_o, mem_data_i      memory port (synchronous-read BRAM behind it)
module mem_arb #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 8,
    parameter int ADDR_BUS = 32,
    parameter int DATA_BUS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               lock_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ-1:0][ADDR_BUS-1:0] addr_i,
    input  logic [NUM_REQ-1:0][3:0]          width_i,
    input  logic [NUM_REQ-1:0][DATA_BUS-1:0] wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_BUS-1:0]              rdata_o,
    output logic                             hold_err_o,
    output logic                             mem_ce_o,
    output logic                             mem_we_o,
    output logic [ADDR_BUS-1:0]              mem_addr_o,
    output logic [3:0]                       mem_width_o,
    output logic [DATA_BUS-1:0]              mem_data_o,
    input  logic [DATA_BUS-1:0]              mem_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic {FREE, OWNED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
    logic               hold_err_q, hold_err_d;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Requester selection: the owner only while OWNED, else first request
    // found scanning upward from ptr with wrap-around.
    always_comb begin
        sel_idx  = owner_q;
        sel_vld  = 1'b0;
        cand_sum = '0;
        cand     = '0;
        if (state_q == OWNED) begin
            sel_vld = req_i[owner_q];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(i);
                if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
                cand = cand_sum[IDX_W-1:0];
                if (!sel_vld && req_i[cand]) begin
                    sel_vld = 1'b1;
                    sel_idx = cand;
                end
            end
        end
    end

    // Grant and memory port. Grants are masked while reset is asserted so a
    // request present during reset is never issued.
    always_comb begin
        gnt_o       = '0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = '0;
        mem_data_o  = '0;
        if (sel_vld && !rst) begin
            gnt_o[sel_idx] = 1'b1;
            mem_ce_o       = 1'b1;
            mem_we_o       = we_i[sel_idx];
            mem_addr_o     = addr_i[sel_idx];
            mem_width_o    = width_i[sel_idx];
            mem_data_o     = wdata_i[sel_idx];
        end
    end

    // Ownership / pointer / hold-counter next state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q;
        rd_pend_d  = gnt_o & ~we_i;
        cnt_inc    = hold_cnt_q + 1'b1;
        case (state_q)
            FREE: begin
                if (sel_vld) begin
                    ptr_d = next_idx(sel_idx);
                    if (lock_i[sel_idx]) begin
                        // With MAX_HOLD==1 the single locked grant is already
                        // the limit, so it releases straight away.
                        if (MAX_HOLD == 1) begin
                            hold_err_d = 1'b1;
                        end else begin
                            state_d    = OWNED;
                            owner_d    = sel_idx;
                            hold_cnt_d = CNT_W'(1);
                        end
                    end
                end
            end
            OWNED: begin
                // Dropping lock releases whether or not the owner issued.
                if (!lock_i[owner_q]) begin
                    state_d    = FREE;
                    hold_cnt_d = '0;
                end else if (cnt_inc == HOLD_LIM) begin
                    // Count reaches the limit at this edge: forced release,
                    // which caps a continuous burst at MAX_HOLD grants.
                    state_d    = FREE;
                    hold_cnt_d = '0;
                    hold_err_d = 1'b1;
                    ptr_d      = next_idx(owner_q);
                end else begin
                    hold_cnt_d = cnt_inc;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FREE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            rd_pend_q  <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend_q  <= rd_pend_d;
            hold_err_q <= hold_err_d;
        end
    end

    assign rvalid_o   = rd_pend_q;
    assign rdata_o    = mem_data_i;
    assign hold_err_o = hold_err_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus randomized traffic for mem_arb, checked
// every cycle against a queue/integer-level model of the arbitration rules,
// with a synchronous-read BRAM model on the memory port.
module tb_mem_arb;
    localparam int N  = 3;
    localparam int MH = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_i, lock_i, we_i;
    logic [N-1:0][AW-1:0] addr_i;
    logic [N-1:0][3:0]    width_i;
    logic [N-1:0][DW-1:0] wdata_i;
    logic [N-1:0]         gnt_o, rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 hold_err_o, mem_ce_o, mem_we_o;
    logic [AW-1:0]        mem_addr_o;
    logic [3:0]           mem_width_o;
    logic [DW-1:0]        mem_data_o;
    logic [DW-1:0]        mem_data_i;

    mem_arb #(.NUM_REQ(N), .MAX_HOLD(MH), .ADDR_BUS(AW), .DATA_BUS(DW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
        .addr_i(addr_i), .width_i(width_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .hold_err_o(hold_err_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM (word addressed, width ignored).
    logic [DW-1:0] bram   [0:1023];
    logic [DW-1:0] shadow [0:1023];

    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) bram[mem_addr_o[9:0]] <= mem_data_o;
            else          mem_data_i <= bram[mem_addr_o[9:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner = -1 when free, rd = -1 when no read pending.
    int            m_owner, m_ptr, m_cnt, m_rd, g;
    logic          m_herr;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  e_gnt, e_rv;

    initial begin
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_rd = -1; m_herr = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_gnt", gnt_o, 0);
                chk("rst_ce", mem_ce_o, 0);
                chk("rst_rvalid", rvalid_o, 0);
                chk("rst_herr", hold_err_o, 0);
                m_owner = -1; m_ptr = 0; m_cnt = 0; m_rd = -1; m_herr = 1'b0;
            end else begin
                g = -1;
                if (m_owner < 0) begin
                    for (int i = 0; i < N; i++)
                        if (g < 0 && req_i[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                end else if (req_i[m_owner]) begin
                    g = m_owner;
                end
                e_gnt = '0;
                if (g >= 0) e_gnt[g] = 1'b1;
                e_rv = '0;
                if (m_rd >= 0) e_rv[m_rd] = 1'b1;
                chk("gnt", gnt_o, e_gnt);
                chk("mem_ce", mem_ce_o, g >= 0);
                chk("mem_we", mem_we_o, (g >= 0) ? we_i[g] : 1'b0);
                chk("mem_addr", mem_addr_o, (g >= 0) ? addr_i[g] : '0);
                chk("mem_width", mem_width_o, (g >= 0) ? width_i[g] : 4'h0);
                chk("mem_data", mem_data_o, (g >= 0) ? wdata_i[g] : '0);
                chk("rvalid", rvalid_o, e_rv);
                if (m_rd >= 0) chk("rdata", rdata_o, m_rdata);
                chk("hold_err", hold_err_o, m_herr);
                // advance to the next clock edge
                if (g >= 0 && !we_i[g]) begin
                    m_rd = g;
                    m_rdata = shadow[addr_i[g][9:0]];
                end else begin
                    m_rd = -1;
                end
                if (g >= 0 && we_i[g]) shadow[addr_i[g][9:0]] = wdata_i[g];
                if (m_owner < 0) begin
                    if (g >= 0) begin
                        m_ptr = (g + 1) % N;
                        if (lock_i[g]) begin m_owner = g; m_cnt = 1; end
                    end
                end else if (!lock_i[m_owner]) begin
                    m_owner = -1; m_cnt = 0;
                end else if (m_cnt + 1 >= MH) begin
                    m_herr = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        for (int r = 0; r < N; r++) width_i[r] = 4'd4;
    endtask

    logic [DW-1:0] burst_exp [0:3];
    logic [N-1:0]  rr_exp [0:5];
    int            lock_pct;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]   = 32'h5a5a_0000 ^ DW'(i * 32'h0101_0101);
            shadow[i] = 32'h5a5a_0000 ^ DW'(i * 32'h0101_0101);
        end
        burst_exp[0] = 32'hb7ac_f62c; burst_exp[1] = 32'hdead_beef;
        burst_exp[2] = 32'hface_0001; burst_exp[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            bram[32'h21c + i]   = burst_exp[i];
            shadow[32'h21c + i] = burst_exp[i];
        end
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
        mem_data_i = '0;
        idle();
        rst = 1'b1;
        req_i = 3'b111;

        // Reset held 3 cycles with every requester asking.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_gnt_lit", gnt_o, 0);
            chk("reset_ce_lit", mem_ce_o, 0);
        end

        // Round-robin with all requests high, no locks.
        step(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            @(negedge clk);
            chk("rr_seq_lit", gnt_o, rr_exp[c]);
        end

        // Bring ptr to 1 so requester 1 wins the burst start.
        step(); idle(); req_i = 3'b001; we_i = 3'b001;
        @(negedge clk);
        chk("pre_burst_lit", gnt_o, 3'b001);

        // Locked 4-word read burst by requester 1, requester 0 also asking.
        for (int i = 0; i < 5; i++) begin
            step(); idle();
            we_i[0] = 1'b1; addr_i[0] = 32'h50; wdata_i[0] = 32'hcafe_0000;
            if (i < 4) begin
                req_i = 3'b011;
                lock_i[1] = (i < 3);
                addr_i[1] = 32'h21c + i;
            end else begin
                req_i = 3'b001;
            end
            @(negedge clk);
            chk("burst_gnt_lit", gnt_o, (i < 4) ? 3'b010 : 3'b001);
            if (i >= 1) begin
                chk("burst_rvalid_lit", rvalid_o, 3'b010);
                chk("burst_rdata_lit", rdata_o, burst_exp[i-1]);
            end
        end

        // Forced release: requester 2 holds req+lock, requester 0 waits.
        for (int i = 0; i < 9; i++) begin
            step(); idle();
            req_i = 3'b101; lock_i = 3'b100;
            addr_i[2] = 32'h30 + i; addr_i[0] = 32'h40;
            @(negedge clk);
            chk("force_gnt_lit", gnt_o, (i < 8) ? 3'b100 : 3'b001);
            chk("force_herr_lit", hold_err_o, i == 8);
        end

        // Write then read of the same address.
        step(); idle();
        req_i = 3'b001; we_i = 3'b001; addr_i[0] = 32'h10; wdata_i[0] = 32'h1234_5678;
        @(negedge clk);
        chk("wr_gnt_lit", gnt_o, 3'b001);
        step(); idle();
        req_i = 3'b010; addr_i[1] = 32'h10;
        @(negedge clk);
        chk("rd_gnt_lit", gnt_o, 3'b010);
        chk("wr_no_rvalid_lit", rvalid_o, 3'b000);
        step(); idle();
        @(negedge clk);
        chk("rd_rvalid_lit", rvalid_o, 3'b010);
        chk("rd_rdata_lit", rdata_o, 32'h1234_5678);

        // Reset in the middle of a locked read burst.
        for (int i = 0; i < 2; i++) begin
            step(); idle();
            req_i = 3'b010; lock_i = 3'b010; addr_i[1] = 32'h21c + i;
        end
        step(); rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt_lit", gnt_o, 0);
        chk("midrst_rvalid_lit", rvalid_o, 0);
        chk("midrst_herr_lit", hold_err_o, 0);
        step(); rst = 1'b0; idle();
        @(negedge clk);
        chk("postrst_rvalid_lit", rvalid_o, 0);
        step(); req_i = 3'b111;
        @(negedge clk);
        chk("postrst_ptr0_lit", gnt_o, 3'b001);

        // Randomized traffic with varying lock pressure and rare resets.
        lock_pct = 10;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: lock_pct = 10;
                    1: lock_pct = 50;
                    default: lock_pct = 95;
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            for (int r = 0; r < N; r++) begin
                req_i[r]   = ($urandom_range(0, 99) < 60);
                lock_i[r]  = ($urandom_range(0, 99) < lock_pct);
                we_i[r]    = ($urandom_range(0, 1) == 1);
                addr_i[r]  = AW'($urandom_range(0, 63));
                width_i[r] = 4'($urandom_range(0, 15));
                wdata_i[r] = $urandom;
            end
        end

        step(); rst = 1'b0; idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
